serial_tx_fifo: RTL and testbench

Buffered 8N1 UART transmitter that consumes the character write strobe produced by the SFR block's serial-out address (SOUT and above). It decouples CPU '.' output bursts from line rate through a FIFO, so the CPU never has to poll a busy flag for short strings. It also exposes status (busy, full, level, overflow) that the SFR block can map to a readable register.

---
 rtl/serial_pkg.sv | 8 +
 rtl/sync_fifo.sv | 38 +++
 rtl/serial_tx_fifo.sv | 89 ++++++++
 tb/tb_serial_tx_fifo.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// serial_pkg: shared types and helpers for the buffered UART transmitter
package serial_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
  localparam int FRAME_BITS = 10;
  function automatic int baud_div(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: show-ahead FIFO; a push while full is only taken alongside a pop
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic wr, rd;
  assign full  = level == LW'(DEPTH);
  assign empty = level == '0;
  assign wr    = push & (~full | pop);
  assign rd    = pop & ~empty;
  assign dout  = mem[rptr];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (wr) wptr <= wptr + AW'(1);
      if (rd) rptr <= rptr + AW'(1);
      level <= level + LW'(wr) - LW'(rd);
    end
  end
  always_ff @(posedge clk) if (wr) mem[wptr] <= din;
endmodule

// File: rtl/serial_tx_fifo.sv
// serial_tx_fifo: 8N1 UART transmitter fed by a FIFO of edge-detected write strobes
module serial_tx_fifo
  import serial_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 115_200,
  parameter int DEPTH  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             char,
  input  logic                   valid,
  input  logic                   clr_ovf,
  output logic                   uart_tx,
  output logic                   busy,
  output logic                   full,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow
);
  localparam int BAUD_DIV = baud_div(CLK_HZ, BAUD);
  localparam int TW = $clog2(BAUD_DIV);
  localparam logic [TW-1:0] TOP = TW'(BAUD_DIV - 1);
  localparam logic [2:0] LAST_BIT = 3'(FRAME_BITS - 3);
  tx_state_t state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic [2:0] bit_idx, bit_n;
  logic [7:0] shift, shift_n, dout;
  logic valid_q, push, pop, empty, drop;
  assign push = valid & ~valid_q;
  assign drop = push & full & ~pop;
  assign busy = (state != IDLE) | (level != '0);
  sync_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .din(char),
    .dout(dout), .full(full), .empty(empty), .level(level)
  );
  always_comb begin
    state_n = state;
    timer_n = timer;
    bit_n   = bit_idx;
    shift_n = shift;
    pop     = 1'b0;
    unique case (state)
      IDLE: if (!empty) begin
        pop     = 1'b1;
        shift_n = dout;
        timer_n = TOP;
        state_n = START;
      end
      START: if (timer == '0) begin
        timer_n = TOP;
        bit_n   = '0;
        state_n = DATA;
      end else timer_n = timer - TW'(1);
      DATA: if (timer == '0) begin
        timer_n = TOP;
        shift_n = shift >> 1;
        bit_n   = bit_idx + 3'd1;
        state_n = (bit_idx == LAST_BIT) ? STOP : DATA;
      end else timer_n = timer - TW'(1);
      STOP: if (timer == '0) begin
        // back-to-back: next frame's start bit follows the stop bit directly
        pop     = ~empty;
        shift_n = empty ? shift : dout;
        timer_n = empty ? '0 : TOP;
        state_n = empty ? IDLE : START;
      end else timer_n = timer - TW'(1);
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      timer    <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      valid_q  <= 1'b0;
      overflow <= 1'b0;
      uart_tx  <= 1'b1;
    end else begin
      state    <= state_n;
      timer    <= timer_n;
      bit_idx  <= bit_n;
      shift    <= shift_n;
      valid_q  <= valid;
      overflow <= drop | (overflow & ~clr_ovf);
      uart_tx  <= (state == START) ? 1'b0 : (state == DATA) ? shift[0] : 1'b1;
    end
  end
endmodule

// File: tb/tb_serial_tx_fifo.sv
// tb_serial_tx_fifo: directed scenarios for serial_tx_fifo at BAUD_DIV=10, DEPTH=4
module tb_serial_tx_fifo;
  logic clk = 0, rst = 1, valid = 0, clr_ovf = 0;
  logic [7:0] char = 8'h00;
  logic uart_tx, busy, full, overflow;
  logic [2:0] level;
  int checks = 0, errors = 0, cyc = 0;

  serial_tx_fifo #(.CLK_HZ(1000), .BAUD(100), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .char(char), .valid(valid), .clr_ovf(clr_ovf),
    .uart_tx(uart_tx), .busy(busy), .full(full), .level(level), .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task tick;
    @(posedge clk);
    #1;
  endtask

  task do_reset;
    rst = 1; valid = 0; clr_ovf = 0;
    tick;
    rst = 0;
    tick;
  endtask

  task push_byte(input logic [7:0] c);
    char = c; valid = 1;
    tick;
    valid = 0;
    tick;
  endtask

  // expected line level after edge n for a frame whose start bit appears at edge s
  function automatic logic frame_bit(input logic [7:0] b, input int n, input int s);
    int k;
    if (n < s) return 1'b1;
    k = (n - s) / 10;
    if (k == 0) return 1'b0;
    if (k >= 9) return 1'b1;
    return b[k-1];
  endfunction

  // line receiver: finds a start bit, samples mid-bit, leaves caller mid stop bit
  task automatic rx_byte(output logic [7:0] b, output logic stop_ok, output int t0, output logic to);
    to = 1; b = '0; stop_ok = 0; t0 = 0;
    for (int i = 0; i < 300; i++) begin
      tick;
      if (uart_tx === 1'b0) begin
        to = 0; t0 = cyc;
        break;
      end
    end
    if (!to) begin
      repeat (5) tick;
      for (int k = 0; k < 8; k++) begin
        repeat (10) tick;
        b[k] = uart_tx;
      end
      repeat (10) tick;
      stop_ok = uart_tx;
    end
  endtask

  task test_reset;
    rst = 1;
    tick; tick;
    checks++; if ({uart_tx, busy, full, level, overflow} !== 7'b1_0_0_000_0) begin
      errors++; $display("FAIL reset: tx/busy/full/level/ovf got %b %b %b %0d %b want 1 0 0 0 0", uart_tx, busy, full, level, overflow);
    end
    rst = 0;
    tick;
  endtask

  task test_single;
    logic exp;
    do_reset;
    char = 8'h55; valid = 1;
    for (int n = 0; n <= 102; n++) begin
      tick;
      if (n == 0) begin
        valid = 0;
        checks++; if (level !== 3'd1 || busy !== 1'b1) begin
          errors++; $display("FAIL single_push: level %0d busy %b want 1 1", level, busy);
        end
      end
      if (n == 1) begin
        checks++; if (uart_tx !== 1'b1 || level !== 3'd0) begin
          errors++; $display("FAIL single_latency: tx %b level %0d want 1 0", uart_tx, level);
        end
      end
      if (n >= 2 && n <= 101) begin
        exp = frame_bit(8'h55, n, 2);
        checks++; if (uart_tx !== exp) begin
          errors++; $display("FAIL single_line edge %0d: got %b want %b", n, uart_tx, exp);
        end
      end
      if (n == 102) begin
        checks++; if (busy !== 1'b0) begin
          errors++; $display("FAIL single_idle: busy %b want 0", busy);
        end
      end
    end
  endtask

  task test_held_valid;
    logic exp;
    logic [2:0] maxl;
    do_reset;
    maxl = 0;
    char = 8'h41; valid = 1;
    for (int n = 0; n <= 130; n++) begin
      tick;
      if (n == 49) valid = 0;
      if (level > maxl) maxl = level;
      if (n >= 2) begin
        exp = frame_bit(8'h41, n, 2);
        checks++; if (uart_tx !== exp) begin
          errors++; $display("FAIL held_line edge %0d: got %b want %b", n, uart_tx, exp);
        end
      end
    end
    checks++; if (maxl !== 3'd1 || busy !== 1'b0) begin
      errors++; $display("FAIL held_once: peak level %0d busy %b want 1 0", maxl, busy);
    end
  endtask

  task test_burst;
    logic exp, st, to;
    logic [7:0] b;
    int base, t0;
    do_reset;
    base = cyc;
    for (int i = 1; i <= 5; i++) push_byte(8'(i));
    checks++; if (level !== 3'd4 || full !== 1'b1 || overflow !== 1'b0) begin
      errors++; $display("FAIL burst_full: level %0d full %b ovf %b want 4 1 0", level, full, overflow);
    end
    push_byte(8'h06);
    checks++; if (overflow !== 1'b1 || level !== 3'd4) begin
      errors++; $display("FAIL burst_drop: ovf %b level %0d want 1 4", overflow, level);
    end
    for (int n = 12; n <= 101; n++) begin
      tick;
      exp = frame_bit(8'h01, n, 2);
      checks++; if (uart_tx !== exp) begin
        errors++; $display("FAIL burst_first edge %0d: got %b want %b", n, uart_tx, exp);
      end
    end
    for (int i = 2; i <= 5; i++) begin
      rx_byte(b, st, t0, to);
      checks++; if (to || b !== 8'(i) || !st || t0 !== base + 1 + 2 + 100 * (i - 1)) begin
        errors++; $display("FAIL burst_frame %0d: byte %h stop %b t %0d timeout %b want %h 1 %0d 0", i, b, st, t0 - base - 1, to, 8'(i), 2 + 100 * (i - 1));
      end
    end
    for (int i = 0; i < 200 && busy; i++) tick;
    checks++; if (busy !== 1'b0 || cyc !== base + 1 + 501) begin
      errors++; $display("FAIL burst_end: busy %b at edge %0d want 0 at 501", busy, cyc - base - 1);
    end
  endtask

  task test_full_pop_push;
    logic st, to;
    logic [7:0] b;
    int base, t0;
    do_reset;
    base = cyc;
    for (int i = 0; i < 5; i++) push_byte(8'h11 + 8'(i));
    repeat (91) tick;
    checks++; if (level !== 3'd4 || full !== 1'b1) begin
      errors++; $display("FAIL fpp_pre: level %0d full %b want 4 1", level, full);
    end
    char = 8'h16; valid = 1;
    tick;
    valid = 0;
    checks++; if (level !== 3'd4 || full !== 1'b1 || overflow !== 1'b0) begin
      errors++; $display("FAIL fpp_accept: level %0d full %b ovf %b want 4 1 0", level, full, overflow);
    end
    for (int i = 0; i < 5; i++) begin
      rx_byte(b, st, t0, to);
      checks++; if (to || b !== 8'h12 + 8'(i) || !st || t0 !== base + 1 + 102 + 100 * i) begin
        errors++; $display("FAIL fpp_frame %0d: byte %h stop %b t %0d timeout %b want %h 1 %0d 0", i, b, st, t0 - base - 1, to, 8'h12 + 8'(i), 102 + 100 * i);
      end
    end
  endtask

  task test_reset_mid;
    logic st, to, bad;
    logic [7:0] b;
    int e0, t0;
    do_reset;
    push_byte(8'hA5);
    push_byte(8'h33);
    checks++; if (level !== 3'd1) begin
      errors++; $display("FAIL rst_mid_level: got %0d want 1", level);
    end
    repeat (42) tick;
    checks++; if (uart_tx !== 1'b0) begin
      errors++; $display("FAIL rst_mid_bit3: got %b want 0", uart_tx);
    end
    rst = 1;
    #1;
    checks++; if ({uart_tx, busy, full, level, overflow} !== 7'b1_0_0_000_0) begin
      errors++; $display("FAIL rst_mid_async: tx/busy/full/level/ovf got %b %b %b %0d %b want 1 0 0 0 0", uart_tx, busy, full, level, overflow);
    end
    tick;
    rst = 0;
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      tick;
      if (uart_tx !== 1'b1 || busy !== 1'b0) bad = 1;
    end
    checks++; if (bad) begin
      errors++; $display("FAIL rst_mid_resume: line or busy active after reset, got bad=%b want 0", bad);
    end
    char = 8'h0F; valid = 1;
    e0 = cyc + 1;
    tick;
    valid = 0;
    rx_byte(b, st, t0, to);
    checks++; if (to || b !== 8'h0F || !st || t0 !== e0 + 2) begin
      errors++; $display("FAIL rst_mid_after: byte %h stop %b latency %0d timeout %b want 0f 1 2 0", b, st, t0 - e0, to);
    end
  endtask

  task test_overflow_clear;
    do_reset;
    for (int i = 0; i < 6; i++) push_byte(8'hC0 + 8'(i));
    checks++; if (overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_set: got %b want 1", overflow);
    end
    clr_ovf = 1;
    tick;
    clr_ovf = 0;
    checks++; if (overflow !== 1'b0) begin
      errors++; $display("FAIL ovf_clear: got %b want 0", overflow);
    end
    char = 8'hEE; valid = 1; clr_ovf = 1;
    tick;
    valid = 0;
    checks++; if (overflow !== 1'b1 || level !== 3'd4) begin
      errors++; $display("FAIL ovf_set_wins: ovf %b level %0d want 1 4", overflow, level);
    end
    tick;
    clr_ovf = 0;
    checks++; if (overflow !== 1'b0 || level !== 3'd4) begin
      errors++; $display("FAIL ovf_clear2: ovf %b level %0d want 0 4", overflow, level);
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_held_valid;
    test_burst;
    test_full_pop_push;
    test_reset_mid;
    test_overflow_clear;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
